// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad entry controller for a hex calculator.
// It collects hex digits into two operands, latches the operation and
// launches an external ALU. It then waits for completion or a timeout
// and holds the displayed result until the next key arrives.
//
// Key interface: key_valid is a one-cycle strobe with no ready/backpressure.
// A key is consumed on the rising edge where key_valid is high. A key that
// has no meaning in the current state is dropped with no side effects.
// alu_start is a one-cycle launch pulse. alu_done is a one-cycle completion
// strobe with alu_result valid in the same cycle. It is honoured only in EXEC.
module calc_entry_ctrl #(
    parameter int N       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic          key_is_cmd,
    input  logic [3:0]    key_val,
    output logic [15:0]   entry_hex,
    output logic [N-1:0]  op_a,
    output logic [N-1:0]  op_b,
    output logic [1:0]    alu_op,
    output logic          alu_start,
    input  logic          alu_done,
    input  logic [N-1:0]  alu_result,
    output logic [N-1:0]  result,
    output logic          result_valid,
    output logic          err,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        EXEC    = 2'd2,
        SHOW    = 2'd3
    } state_t;

    localparam int          TW          = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
    // Only the last N/4 typed digits are kept in the entry register.
    localparam logic [15:0] ENTRY_MASK  = 16'((32'h1 << N) - 32'h1);

    state_t         state_q, state_d;
    logic [15:0]    entry_hex_q, entry_hex_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic [1:0]     alu_op_q, alu_op_d;
    logic           alu_start_q, alu_start_d;
    logic [N-1:0]   result_q, result_d;
    logic           result_valid_q, result_valid_d;
    logic           err_q, err_d;
    logic [TW-1:0]  timer_q, timer_d;

    logic           is_digit, is_op, is_eq, is_clr;
    logic [15:0]    entry_shifted;

    // Decode the key strobe into the four classes the FSM reacts to.
    always_comb begin
        is_digit      = key_valid && !key_is_cmd;
        is_op         = key_valid && key_is_cmd && (key_val < 4'd4);
        is_eq         = key_valid && key_is_cmd && (key_val == 4'd4);
        is_clr        = key_valid && key_is_cmd && (key_val == 4'd5);
        entry_shifted = {entry_hex_q[11:0], key_val} & ENTRY_MASK;
    end

    // Next-state and datapath updates; clear takes priority over everything.
    always_comb begin
        state_d        = state_q;
        entry_hex_d    = entry_hex_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        alu_op_d       = alu_op_q;
        alu_start_d    = 1'b0;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        err_d          = err_q;
        timer_d        = timer_q;

        if (is_clr) begin
            state_d        = ENTER_A;
            entry_hex_d    = '0;
            op_a_d         = '0;
            op_b_d         = '0;
            alu_op_d       = '0;
            result_d       = '0;
            result_valid_d = 1'b0;
            err_d          = 1'b0;
            timer_d        = '0;
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (is_digit) begin
                        entry_hex_d = entry_shifted;
                    end else if (is_op) begin
                        op_a_d      = entry_hex_q[N-1:0];
                        alu_op_d    = key_val[1:0];
                        entry_hex_d = '0;
                        state_d     = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit) begin
                        entry_hex_d = entry_shifted;
                    end else if (is_op) begin
                        alu_op_d = key_val[1:0];
                    end else if (is_eq) begin
                        op_b_d      = entry_hex_q[N-1:0];
                        alu_start_d = 1'b1;
                        timer_d     = '0;
                        state_d     = EXEC;
                    end
                end
                EXEC: begin
                    if (alu_done) begin
                        result_d       = alu_result;
                        result_valid_d = 1'b1;
                        err_d          = 1'b0;
                        state_d        = SHOW;
                    end else if (timer_q == TIMER_MAX) begin
                        result_d       = '0;
                        result_valid_d = 1'b1;
                        err_d          = 1'b1;
                        state_d        = SHOW;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                SHOW: begin
                    if (is_digit) begin
                        result_valid_d = 1'b0;
                        err_d          = 1'b0;
                        entry_hex_d    = {12'h000, key_val} & ENTRY_MASK;
                        state_d        = ENTER_A;
                    end else if (is_op) begin
                        op_a_d         = result_q;
                        alu_op_d       = key_val[1:0];
                        entry_hex_d    = '0;
                        result_valid_d = 1'b0;
                        err_d          = 1'b0;
                        state_d        = ENTER_B;
                    end else if (is_eq) begin
                        op_a_d         = result_q;
                        alu_start_d    = 1'b1;
                        result_valid_d = 1'b0;
                        err_d          = 1'b0;
                        timer_d        = '0;
                        state_d        = EXEC;
                    end
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ENTER_A;
            entry_hex_q    <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            alu_op_q       <= '0;
            alu_start_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            entry_hex_q    <= entry_hex_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            alu_op_q       <= alu_op_d;
            alu_start_q    <= alu_start_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
            timer_q        <= timer_d;
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        entry_hex    = entry_hex_q;
        op_a         = op_a_q;
        op_b         = op_b_q;
        alu_op       = alu_op_q;
        alu_start    = alu_start_q;
        result       = result_q;
        result_valid = result_valid_q;
        err          = err_q;
        busy         = (state_q == EXEC);
        dbg_state    = state_q;
    end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Testbench for calc_entry_ctrl: keypad sequences, ALU responder, scoreboard.
module tb_calc_entry_ctrl;

    localparam int N       = 8;
    localparam int TIMEOUT = 255;
    localparam logic [1:0] S_ENTER_A = 2'd0;
    localparam logic [1:0] S_ENTER_B = 2'd1;
    localparam logic [1:0] S_EXEC    = 2'd2;
    localparam logic [1:0] S_SHOW    = 2'd3;
    localparam logic [3:0] C_ADD = 4'd0, C_SUB = 4'd1, C_MUL = 4'd2;
    localparam logic [3:0] C_EQ  = 4'd4, C_CLR = 4'd5;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid, key_is_cmd;
    logic [3:0]    key_val;
    logic [15:0]   entry_hex;
    logic [N-1:0]  op_a, op_b, alu_result, result;
    logic [1:0]    alu_op, dbg_state;
    logic          alu_start, alu_done, result_valid, err, busy;

    int n_checks = 0;
    int n_fails  = 0;
    logic [N-1:0] exp_q[$];

    calc_entry_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_is_cmd(key_is_cmd),
        .key_val(key_val), .entry_hex(entry_hex), .op_a(op_a), .op_b(op_b),
        .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
        .alu_result(alu_result), .result(result), .result_valid(result_valid),
        .err(err), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock: 10 ns period
    always #5 clk = ~clk;

    // Reference ALU used to build expected results from the typed operands.
    function automatic logic [N-1:0] calc(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [1:0] op);
        case (op)
            2'd0:    calc = a + b;
            2'd1:    calc = a - b;
            2'd2:    calc = N'(a * b);
            default: calc = (b == '0) ? '0 : a / b;
        endcase
    endfunction

    // Driver: one key strobe, starting and ending on a falling edge.
    task automatic press(input logic cmd, input logic [3:0] v);
        key_is_cmd = cmd;
        key_val    = v;
        key_valid  = 1'b1;
        @(negedge clk);
        key_valid  = 1'b0;
        key_val    = $urandom_range(0, 15);
    endtask

    // ALU responder: waits for alu_start, answers after dly cycles, then
    // pops the scoreboard and compares the displayed result.
    task automatic serve_alu(input logic [N-1:0] val, input int dly);
        int budget = 0;
        int starts;
        logic [N-1:0] exp;
        while (alu_start !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (alu_start !== 1'b1) begin
            n_fails++;
            $display("FAIL alu_start_seen: got %b want 1", alu_start);
        end
        starts = 1;
        repeat (dly) begin
            @(negedge clk);
            if (alu_start === 1'b1) starts++;
        end
        alu_done   = 1'b1;
        alu_result = val;
        @(negedge clk);
        alu_done   = 1'b0;
        alu_result = $urandom_range(0, 255);
        n_checks++;
        if (starts !== 1) begin
            n_fails++;
            $display("FAIL alu_start_pulses: got %0d want 1", starts);
        end
        n_checks++;
        if (result_valid !== 1'b1 || err !== 1'b0) begin
            n_fails++;
            $display("FAIL result_valid_latency: got rv=%b err=%b want rv=1 err=0", result_valid, err);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL scoreboard_empty: got result %h with nothing expected", result);
        end else begin
            exp = exp_q.pop_front();
            if (result !== exp) begin
                n_fails++;
                $display("FAIL result: got %h want %h", result, exp);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({entry_hex, op_a, op_b, alu_op, alu_start, result, result_valid, err, busy, dbg_state} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got eh=%h a=%h b=%h op=%h st=%b r=%h rv=%b e=%b busy=%b s=%0d want all 0",
                     entry_hex, op_a, op_b, alu_op, alu_start, result, result_valid, err, busy, dbg_state);
        end
        rst = 1'b0;
        press(1'b0, 4'h7);
        n_checks++;
        if (entry_hex !== 16'h0007) begin
            n_fails++;
            $display("FAIL first_key_after_reset: got %h want 0007", entry_hex);
        end
        press(1'b1, C_CLR);
    endtask

    task automatic test_basic;
        press(1'b0, 4'h1); press(1'b0, 4'h2); press(1'b1, C_ADD);
        press(1'b0, 4'h3); press(1'b0, 4'h4);
        exp_q.push_back(calc(8'h12, 8'h34, 2'd0));
        press(1'b1, C_EQ);
        n_checks++;
        if (op_a !== 8'h12 || op_b !== 8'h34 || alu_op !== 2'd0 || busy !== 1'b1) begin
            n_fails++;
            $display("FAIL basic_operands: got a=%h b=%h op=%0d busy=%b want a=12 b=34 op=0 busy=1",
                     op_a, op_b, alu_op, busy);
        end
        serve_alu(8'h46, 2);
        n_checks++;
        if (dbg_state !== S_SHOW) begin
            n_fails++;
            $display("FAIL basic_state: got %0d want %0d", dbg_state, S_SHOW);
        end
    endtask

    task automatic test_digits;
        press(1'b1, C_CLR);
        press(1'b0, 4'hA); press(1'b0, 4'hB); press(1'b0, 4'hC);
        n_checks++;
        if (entry_hex !== 16'h00BC) begin
            n_fails++;
            $display("FAIL digit_window: got %h want 00bc", entry_hex);
        end
        press(1'b1, C_SUB);
        n_checks++;
        if (entry_hex !== 16'h0000 || dbg_state !== S_ENTER_B) begin
            n_fails++;
            $display("FAIL op_key_clears_entry: got eh=%h s=%0d want 0000 s=1", entry_hex, dbg_state);
        end
        press(1'b0, 4'h1);
        press(1'b1, 4'd9);
        n_checks++;
        if (entry_hex !== 16'h0001 || dbg_state !== S_ENTER_B) begin
            n_fails++;
            $display("FAIL unused_cmd: got eh=%h s=%0d want 0001 s=1", entry_hex, dbg_state);
        end
        exp_q.push_back(calc(8'hBC, 8'h01, 2'd1));
        press(1'b1, C_EQ);
        n_checks++;
        if (op_a !== 8'hBC || op_b !== 8'h01 || alu_op !== 2'd1) begin
            n_fails++;
            $display("FAIL sub_operands: got a=%h b=%h op=%0d want a=bc b=01 op=1", op_a, op_b, alu_op);
        end
        serve_alu(8'hBB, $urandom_range(0, 4));
    endtask

    task automatic test_enter_a_equals;
        press(1'b1, C_CLR);
        press(1'b0, 4'h5);
        press(1'b1, C_EQ);
        repeat (2) @(negedge clk);
        n_checks++;
        if (dbg_state !== S_ENTER_A || busy !== 1'b0 || alu_start !== 1'b0 || entry_hex !== 16'h0005) begin
            n_fails++;
            $display("FAIL equals_in_enter_a: got s=%0d busy=%b st=%b eh=%h want s=0 busy=0 st=0 eh=0005",
                     dbg_state, busy, alu_start, entry_hex);
        end
    endtask

    task automatic test_timeout;
        int cyc = 0;
        press(1'b1, C_CLR);
        press(1'b0, 4'h5); press(1'b1, C_ADD); press(1'b0, 4'h6);
        exp_q.push_back('0);
        press(1'b1, C_EQ);
        while (result_valid !== 1'b1 && cyc < TIMEOUT + 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc < TIMEOUT || cyc > TIMEOUT + 1) begin
            n_fails++;
            $display("FAIL timeout_cycles: got %0d want %0d..%0d", cyc, TIMEOUT, TIMEOUT + 1);
        end
        n_checks++;
        if (result !== exp_q.pop_front() || err !== 1'b1 || result_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL timeout_result: got r=%h err=%b rv=%b want r=00 err=1 rv=1", result, err, result_valid);
        end
        alu_done   = 1'b1;
        alu_result = 8'h77;
        @(negedge clk);
        alu_done   = 1'b0;
        @(negedge clk);
        n_checks++;
        if (result !== 8'h00 || err !== 1'b1 || dbg_state !== S_SHOW) begin
            n_fails++;
            $display("FAIL late_done_ignored: got r=%h err=%b s=%0d want r=00 err=1 s=3", result, err, dbg_state);
        end
    endtask

    task automatic test_chain;
        press(1'b1, C_CLR);
        press(1'b0, 4'h8); press(1'b1, C_ADD); press(1'b0, 4'h8);
        exp_q.push_back(calc(8'h08, 8'h08, 2'd0));
        press(1'b1, C_EQ);
        serve_alu(8'h10, 1);
        press(1'b1, C_MUL); press(1'b0, 4'h2);
        exp_q.push_back(calc(8'h10, 8'h02, 2'd2));
        press(1'b1, C_EQ);
        n_checks++;
        if (op_a !== 8'h10 || op_b !== 8'h02 || alu_op !== 2'd2 || result_valid !== 1'b0) begin
            n_fails++;
            $display("FAIL chain_operands: got a=%h b=%h op=%0d rv=%b want a=10 b=02 op=2 rv=0",
                     op_a, op_b, alu_op, result_valid);
        end
        serve_alu(8'h20, 3);
        exp_q.push_back(calc(8'h20, 8'h02, 2'd2));
        press(1'b1, C_EQ);
        n_checks++;
        if (op_a !== 8'h20 || op_b !== 8'h02 || alu_op !== 2'd2 || alu_start !== 1'b1) begin
            n_fails++;
            $display("FAIL repeat_equals: got a=%h b=%h op=%0d st=%b want a=20 b=02 op=2 st=1",
                     op_a, op_b, alu_op, alu_start);
        end
        serve_alu(8'h40, 0);
    endtask

    task automatic test_clear_vs_done;
        press(1'b1, C_CLR);
        press(1'b0, 4'h3); press(1'b1, C_ADD); press(1'b0, 4'h4);
        press(1'b1, C_EQ);
        alu_done   = 1'b1;
        alu_result = 8'h99;
        press(1'b1, C_CLR);
        alu_done   = 1'b0;
        n_checks++;
        if (dbg_state !== S_ENTER_A || result !== 8'h00 || result_valid !== 1'b0 || op_a !== 8'h00 || busy !== 1'b0) begin
            n_fails++;
            $display("FAIL clear_beats_done: got s=%0d r=%h rv=%b a=%h busy=%b want s=0 r=00 rv=0 a=00 busy=0",
                     dbg_state, result, result_valid, op_a, busy);
        end
    endtask

    task automatic test_async_reset;
        press(1'b0, 4'h1); press(1'b1, C_ADD); press(1'b0, 4'h2);
        press(1'b1, C_EQ);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({entry_hex, op_a, op_b, alu_op, alu_start, result, result_valid, err, busy} !== '0) begin
            n_fails++;
            $display("FAIL async_reset: got eh=%h a=%h b=%h op=%h st=%b r=%h rv=%b e=%b busy=%b want all 0",
                     entry_hex, op_a, op_b, alu_op, alu_start, result, result_valid, err, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        press(1'b0, 4'hE);
        n_checks++;
        if (entry_hex !== 16'h000E || dbg_state !== S_ENTER_A) begin
            n_fails++;
            $display("FAIL key_after_async_reset: got eh=%h s=%0d want 000e s=0", entry_hex, dbg_state);
        end
    endtask

    initial begin
        rst        = 1'b1;
        key_valid  = 1'b0;
        key_is_cmd = 1'b0;
        key_val    = 4'h0;
        alu_done   = 1'b0;
        alu_result = '0;
        test_reset();
        test_basic();
        test_digits();
        test_enter_a_equals();
        test_timeout();
        test_chain();
        test_clear_vs_done();
        test_async_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
